// File: rtl/fetch_unit_pkg.sv
// Shared processor package: fetch geometry defaults and fetch FSM encoding.
package fetch_unit_pkg;

  localparam int unsigned FU_ADDR_W   = 12;
  localparam int unsigned FU_DATA_W   = 32;
  localparam int unsigned FU_RESET_PC = 0;

  // RUN: decode sees the live ROM word; HOLD: decode sees the captured word.
  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding decode from a synchronous ROM.
// pc drives the ROM directly; req_pc/req_valid track the word currently
// arriving on imem_q. A hold register freezes the word across stalls,
// because the ROM keeps re-reading pc and its output moves on.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = FU_ADDR_W,
  parameter int unsigned DATA_W   = FU_DATA_W,
  parameter int unsigned RESET_PC = FU_RESET_PC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] imem_address,
  input  logic [DATA_W-1:0] imem_q,
  output logic              fd_valid,
  output logic [ADDR_W-1:0] fd_pc,
  output logic [DATA_W-1:0] fd_insn
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              req_valid;
  logic [DATA_W-1:0] hold_insn;
  fetch_state_e      state;

  // Fetch state update; priority reset > redirect > stall > advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RST_PC;
      req_pc    <= RST_PC;
      req_valid <= 1'b0;
      hold_insn <= '0;
      state     <= FS_RUN;
    end else if (redirect_valid) begin
      // The word in flight is from the wrong path: drop it, keep req_pc.
      pc        <= redirect_target;
      req_valid <= 1'b0;
      state     <= FS_RUN;
    end else if (stall) begin
      // Capture only on the first stall edge; later edges just hold.
      if (state == FS_RUN) begin
        hold_insn <= imem_q;
        state     <= FS_HOLD;
      end
    end else begin
      req_pc    <= pc;
      req_valid <= 1'b1;
      pc        <= pc + 1'b1;  // wraps modulo 2^ADDR_W
      state     <= FS_RUN;
    end
  end

  // Outputs: address straight from pc, decode word from ROM or hold register.
  always_comb begin
    imem_address = pc;
    fd_valid     = req_valid;
    fd_pc        = req_pc;
    fd_insn      = (state == FS_HOLD) ? hold_insn : imem_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous ROM model (word n = A000_0000+n).
module tb_fetch_unit;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] imem_address;
  logic [DATA_W-1:0] imem_q;
  logic              fd_valid;
  logic [ADDR_W-1:0] fd_pc;
  logic [DATA_W-1:0] fd_insn;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem_address(imem_address),
    .imem_q(imem_q),
    .fd_valid(fd_valid),
    .fd_pc(fd_pc),
    .fd_insn(fd_insn)
  );

  always #5 clock = ~clock;

  // ROM registers the address at the edge, data visible the following cycle.
  always @(posedge clock) imem_q <= 32'hA000_0000 + {20'h0, imem_address};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [11:0] pc,
                         input logic [31:0] insn);
    chk({tag, ".valid"}, {31'h0, fd_valid}, {31'h0, v});
    chk({tag, ".pc"}, {20'h0, fd_pc}, {20'h0, pc});
    chk({tag, ".insn"}, fd_insn, insn);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

    // Reset state
    step();
    step();
    chk("rst.valid", {31'h0, fd_valid}, 32'h0);
    chk("rst.addr", {20'h0, imem_address}, 32'h0);
    chk("rst.pc", {20'h0, fd_pc}, 32'h0);
    reset = 1'b0;

    // Free run: 0,1,2
    step(); chk_out("run0", 1'b1, 12'h000, 32'hA000_0000);
    step(); chk_out("run1", 1'b1, 12'h001, 32'hA000_0001);
    step(); chk_out("run2", 1'b1, 12'h002, 32'hA000_0002);
    chk("run2.addr", {20'h0, imem_address}, 32'h3);

    // Three stall edges hold pc 2
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall", 1'b1, 12'h002, 32'hA000_0002);
      chk("stall.addr", {20'h0, imem_address}, 32'h3);
    end
    stall = 1'b0;
    step(); chk_out("resume3", 1'b1, 12'h003, 32'hA000_0003);
    step(); chk_out("resume4", 1'b1, 12'h004, 32'hA000_0004);
    step(); chk_out("run5", 1'b1, 12'h005, 32'hA000_0005);

    // Redirect to 0x100: one bubble
    redirect_valid = 1'b1; redirect_target = 12'h100;
    step();
    chk("redir.bubble", {31'h0, fd_valid}, 32'h0);
    chk("redir.addr", {20'h0, imem_address}, 32'h100);
    redirect_valid = 1'b0;
    step(); chk_out("redir.tgt", 1'b1, 12'h100, 32'hA000_0100);
    step(); chk_out("redir.tgt1", 1'b1, 12'h101, 32'hA000_0101);

    // Enter HOLD, then redirect with stall still high
    stall = 1'b1;
    step(); chk_out("hold", 1'b1, 12'h101, 32'hA000_0101);
    redirect_valid = 1'b1; redirect_target = 12'h040;
    step();
    chk("rs.bubble", {31'h0, fd_valid}, 32'h0);
    chk("rs.addr", {20'h0, imem_address}, 32'h040);
    redirect_valid = 1'b0; stall = 1'b0;
    step(); chk_out("rs.tgt", 1'b1, 12'h040, 32'hA000_0040);

    // Redirect near top of address space, wrap
    redirect_valid = 1'b1; redirect_target = 12'hFFE;
    step(); chk("wrap.bubble", {31'h0, fd_valid}, 32'h0);
    redirect_valid = 1'b0;
    step(); chk_out("wrapFFE", 1'b1, 12'hFFE, 32'hA000_0FFE);
    step(); chk_out("wrapFFF", 1'b1, 12'hFFF, 32'hA000_0FFF);
    step(); chk_out("wrap000", 1'b1, 12'h000, 32'hA000_0000);
    chk("wrap.addr", {20'h0, imem_address}, 32'h1);
    step(); chk_out("run1b", 1'b1, 12'h001, 32'hA000_0001);
    step(); chk_out("run2b", 1'b1, 12'h002, 32'hA000_0002);

    // Reset during a 2-cycle stall drops the held word
    stall = 1'b1;
    step(); chk_out("st2a", 1'b1, 12'h002, 32'hA000_0002);
    step(); chk_out("st2b", 1'b1, 12'h002, 32'hA000_0002);
    reset = 1'b1;
    step();
    chk("rststall.valid", {31'h0, fd_valid}, 32'h0);
    chk("rststall.addr", {20'h0, imem_address}, 32'h0);
    reset = 1'b0; stall = 1'b0;
    step(); chk_out("post_rst", 1'b1, 12'h000, 32'hA000_0000);
    step(); chk_out("post_rst1", 1'b1, 12'h001, 32'hA000_0001);

    // Reset together with redirect: pending target discarded
    redirect_valid = 1'b1; redirect_target = 12'h200; reset = 1'b1;
    step();
    chk("rstredir.addr", {20'h0, imem_address}, 32'h0);
    chk("rstredir.valid", {31'h0, fd_valid}, 32'h0);
    redirect_valid = 1'b0; reset = 1'b0;
    step(); chk_out("rstredir.first", 1'b1, 12'h000, 32'hA000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 12: instruction-memory word-address width.
REQ-002 Parameter DATA_W, default 32: instruction width.
REQ-003 Parameter RESET_PC, default 0: PC loaded on reset.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  downstream cannot accept; hold current fetch output.
REQ-007 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-008 redirect_target  input  ADDR_W  new PC when redirect_valid=1.
REQ-009 imem_address  output  ADDR_W  word address to the synchronous ROM.
REQ-010 imem_q  input  DATA_W  ROM data, valid one cycle after the address edge.
REQ-011 fd_valid  output  1  fd_insn/fd_pc hold a real instruction.
REQ-012 fd_pc  output  ADDR_W  address of fd_insn.
REQ-013 fd_insn  output  DATA_W  fetched instruction to decode.

Function
REQ-014 The ROM SHALL be treated as registering its address at the clock edge, with data at imem_q one cycle later and no output register.
REQ-015 imem_address SHALL equal the pc register, with no combinational path from any input.
REQ-016 State SHALL comprise: pc, req_pc, req_valid, hold_insn, and a 2-state FSM {RUN, HOLD}.
REQ-017 Edge priority SHALL be reset > redirect_valid > stall > advance.
REQ-018 Redirect edge: pc<=redirect_target, req_valid<=0, FSM<=RUN, req_pc unchanged; this applies even if stall=1.
REQ-019 Stall edge in RUN: hold_insn<=imem_q, FSM<=HOLD, pc/req_pc/req_valid unchanged.
REQ-020 Stall edge in HOLD: all state unchanged.
REQ-021 Advance edge (no stall, no redirect): req_pc<=pc, req_valid<=1, pc<=pc+1, FSM<=RUN.
REQ-022 pc+1 SHALL wrap modulo 2^ADDR_W (4095 -> 0 at default width), with no flag or error.
REQ-023 fd_valid SHALL equal req_valid, and fd_pc SHALL equal req_pc.
REQ-024 fd_insn SHALL equal hold_insn in HOLD and imem_q in RUN.
REQ-025 Latency: an address presented at edge k SHALL appear on fd_insn/fd_pc after edge k, i.e. during cycle k+1.
REQ-026 Throughput SHALL be one instruction per cycle with no stall or redirect.
REQ-027 Redirect penalty SHALL be exactly one fd_valid=0 cycle; the target instruction SHALL appear in the second cycle after the redirect edge.
REQ-028 fd_insn/fd_pc SHALL be stable across any number of consecutive stall cycles.
REQ-029 fd_insn SHALL be don't-care when fd_valid=0; a stall with fd_valid=0 SHALL still follow REQ-019/020.

Reset
REQ-030 The reset edge SHALL set pc=RESET_PC, req_pc=RESET_PC, req_valid=0, hold_insn=0, FSM=RUN; hence imem_address=RESET_PC and fd_valid=0.
REQ-031 Reset mid-stall or mid-redirect SHALL discard the held instruction and any pending target.
REQ-032 The first edge after reset deasserts SHALL be an advance edge: fd_pc=RESET_PC and fd_valid=1 in the following cycle (unless stall/redirect).

Structure
REQ-033 ADDR_W/DATA_W defaults, RESET_PC and the FSM state encoding SHALL live in the shared processor package.
REQ-034 The block SHALL be flat with no sub-module; the hold register plus mux is small enough to inline.

Verification
REQ-035 Reset, then 4 free-running cycles with ROM word n = 0xA000_0000+n -> fd_pc 0,1,2,3 with fd_insn 0xA0000000..0xA0000003, fd_valid=1 from the first post-reset cycle.
REQ-036 Stall high for 3 cycles while fd_pc=2 -> fd_pc=2 and fd_insn=0xA0000002 held for 4 cycles, imem_address=3 throughout, then 3,4 resume with no gap or duplicate.
REQ-037 Redirect to 0x100 while fd_pc=5 -> next cycle fd_valid=0, following cycle fd_pc=0x100 with fd_insn=0xA0000100.
REQ-038 Redirect to 0x040 together with stall=1 while in HOLD -> redirect wins: FSM RUN, one bubble, then fd_pc=0x040.
REQ-039 Redirect to 0xFFE, run 3 cycles -> fd_pc 0xFFE, 0xFFF, 0x000 (wrap), fd_valid=1 each cycle.
REQ-040 Assert reset during a 2-cycle stall -> next cycle fd_valid=0 and imem_address=0; first post-reset output is fd_pc=0, not the held word.
